// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, cycle conversion and init ROM for the HD44780 write controller
package lcd_pkg;

  typedef enum logic [2:0] {
    S_PON, S_INIT, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_NEXT, S_EXEC
  } lcd_state_e;

  typedef enum logic [1:0] {
    W_INIT1, W_INIT2, W_EXEC, W_LONG
  } lcd_wait_e;

  typedef struct packed {
    logic [7:0] byte_v;
    logic       single;
    lcd_wait_e  wsel;
  } init_step_t;

  localparam logic [7:0] INIT_BYTE_30  = 8'h30;
  localparam logic [7:0] INIT_BYTE_38  = 8'h38;
  localparam logic [7:0] INIT_BYTE_28  = 8'h28;
  localparam logic [3:0] INIT_NIBBLE_2 = 4'h2;
  localparam int unsigned INIT_WAIT1_US = 4100;
  localparam int unsigned INIT_WAIT2_US = 100;
  localparam logic [7:0] LONG_CMD_MASK = 8'hFC;
  localparam logic [2:0] INIT_LAST_8   = 3'd3;
  localparam logic [2:0] INIT_LAST_4   = 3'd4;

  function automatic longint unsigned to_cycles(input longint unsigned t,
                                                input longint unsigned clk_hz,
                                                input longint unsigned scale);
    longint unsigned c;
    c = (t * clk_hz + scale - 64'd1) / scale;
    return (c == 64'd0) ? 64'd1 : c;
  endfunction

  function automatic longint unsigned max_cyc(input longint unsigned a,
                                              input longint unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic [7:0] b, input logic rs);
    return !rs && ((b & LONG_CMD_MASK) == 8'h00) && (b != 8'h00);
  endfunction

  // Single-nibble steps carry their nibble in [7:4] so the 4-bit path sends only the high half.
  function automatic init_step_t init_rom(input logic [2:0] step, input logic bus4);
    init_step_t s;
    s.byte_v = INIT_BYTE_30;
    s.single = bus4;
    s.wsel   = W_EXEC;
    case (step)
      3'd0: s.wsel = W_INIT1;
      3'd1: s.wsel = W_INIT2;
      3'd2: s.wsel = W_EXEC;
      default: begin
        if (!bus4) begin
          s.byte_v = INIT_BYTE_38;
        end else if (step == 3'd3) begin
          s.byte_v = {INIT_NIBBLE_2, 4'h0};
        end else begin
          s.byte_v = INIT_BYTE_28;
          s.single = 1'b0;
        end
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// rtl/lcd_delay_timer.sv - loadable down-counter shared by every controller wait
// done_o is high in the last cycle of a loaded interval; reset preloads the power-on wait.
module lcd_delay_timer #(
  parameter int unsigned  W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == ONE);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// rtl/lcd_hd44780_ctrl.sv - HD44780 write controller: power-on init, byte writes, 8/4-bit bus timing
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BUS_4BIT   = 0,
  parameter int unsigned T_AS_NS    = 60,
  parameter int unsigned T_PW_NS    = 460,
  parameter int unsigned T_H_NS     = 20,
  parameter int unsigned T_EXEC_US  = 40,
  parameter int unsigned T_LONG_US  = 1640,
  parameter int unsigned T_PON_US   = 40000,
  parameter int unsigned T_INIT1_US = INIT_WAIT1_US,
  parameter int unsigned T_INIT2_US = INIT_WAIT2_US
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       write,
  input  logic       data1cmd0,
  output logic       ready,
  output logic [7:0] lcd_data,
  output logic       lcd_en,
  output logic       lcd_regsel,
  output logic       lcd_r1w0
);

  localparam longint unsigned NS = 64'd1_000_000_000;
  localparam longint unsigned US = 64'd1_000_000;
  localparam longint unsigned HZ = 64'(CLK_HZ);

  localparam longint unsigned AS_CYC    = to_cycles(64'(T_AS_NS), HZ, NS);
  localparam longint unsigned PW_CYC    = to_cycles(64'(T_PW_NS), HZ, NS);
  localparam longint unsigned H_CYC     = to_cycles(64'(T_H_NS), HZ, NS);
  localparam longint unsigned EXEC_CYC  = to_cycles(64'(T_EXEC_US), HZ, US);
  localparam longint unsigned LONG_CYC  = to_cycles(64'(T_LONG_US), HZ, US);
  localparam longint unsigned PON_CYC   = to_cycles(64'(T_PON_US), HZ, US);
  localparam longint unsigned INIT1_CYC = to_cycles(64'(T_INIT1_US), HZ, US);
  localparam longint unsigned INIT2_CYC = to_cycles(64'(T_INIT2_US), HZ, US);

  localparam longint unsigned MAX_CYC =
    max_cyc(max_cyc(max_cyc(AS_CYC, PW_CYC), max_cyc(H_CYC, EXEC_CYC)),
            max_cyc(max_cyc(LONG_CYC, PON_CYC), max_cyc(INIT1_CYC, INIT2_CYC)));
  localparam int TW = $clog2(MAX_CYC + 64'd1);

  localparam logic [TW-1:0] AS_C    = TW'(AS_CYC);
  localparam logic [TW-1:0] PW_C    = TW'(PW_CYC);
  localparam logic [TW-1:0] H_C     = TW'(H_CYC);
  localparam logic [TW-1:0] EXEC_C  = TW'(EXEC_CYC);
  localparam logic [TW-1:0] LONG_C  = TW'(LONG_CYC);
  localparam logic [TW-1:0] PON_C   = TW'(PON_CYC);
  localparam logic [TW-1:0] INIT1_C = TW'(INIT1_CYC);
  localparam logic [TW-1:0] INIT2_C = TW'(INIT2_CYC);

  localparam logic       BUS4      = (BUS_4BIT != 0);
  localparam logic [2:0] INIT_LAST = BUS4 ? INIT_LAST_4 : INIT_LAST_8;

  lcd_state_e    state_q, state_d;
  lcd_wait_e     wsel_q, wsel_d;
  logic [7:0]    byte_q, byte_d;
  logic          rs_q, rs_d;
  logic          low_q, low_d;
  logic          single_q, single_d;
  logic          init_q, init_d;
  logic [2:0]    step_q, step_d;
  logic          ready_q, en_q, regsel_q;
  logic [7:0]    lcd_data_q, bus_d;
  logic          tmr_load, tmr_done;
  logic [TW-1:0] tmr_value, exec_val;
  init_step_t    rom_s;

  lcd_delay_timer #(
    .W       (TW),
    .RST_VAL (PON_C)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .done_o  (tmr_done)
  );

  assign rom_s = init_rom(step_q, BUS4);

  always_comb begin
    case (wsel_q)
      W_INIT1: exec_val = INIT1_C;
      W_INIT2: exec_val = INIT2_C;
      W_LONG:  exec_val = LONG_C;
      default: exec_val = EXEC_C;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wsel_d    = wsel_q;
    byte_d    = byte_q;
    rs_d      = rs_q;
    low_d     = low_q;
    single_d  = single_q;
    init_d    = init_q;
    step_d    = step_q;
    tmr_load  = 1'b0;
    tmr_value = AS_C;
    bus_d     = 8'h00;

    case (state_q)
      S_PON: begin
        if (tmr_done) begin
          state_d = S_INIT;
          step_d  = 3'd0;
          init_d  = 1'b1;
        end
      end
      S_INIT: begin
        byte_d   = rom_s.byte_v;
        single_d = rom_s.single;
        wsel_d   = rom_s.wsel;
        rs_d     = 1'b0;
        low_d    = 1'b0;
        state_d  = S_SETUP;
        tmr_load = 1'b1;
      end
      S_IDLE: begin
        if (write) begin
          byte_d   = data;
          rs_d     = data1cmd0;
          single_d = 1'b0;
          low_d    = 1'b0;
          init_d   = 1'b0;
          wsel_d   = is_long_cmd(data, data1cmd0) ? W_LONG : W_EXEC;
          state_d  = S_SETUP;
          tmr_load = 1'b1;
        end
      end
      S_SETUP: begin
        if (tmr_done) begin
          state_d   = S_PULSE;
          tmr_load  = 1'b1;
          tmr_value = PW_C;
        end
      end
      S_PULSE: begin
        if (tmr_done) begin
          state_d   = S_HOLD;
          tmr_load  = 1'b1;
          tmr_value = H_C;
        end
      end
      S_HOLD: begin
        if (tmr_done) begin
          if (BUS4 && !low_q && !single_q) begin
            state_d = S_NEXT;
          end else begin
            state_d   = S_EXEC;
            tmr_load  = 1'b1;
            tmr_value = exec_val;
          end
        end
      end
      S_NEXT: begin
        low_d    = 1'b1;
        state_d  = S_SETUP;
        tmr_load = 1'b1;
      end
      S_EXEC: begin
        if (tmr_done) begin
          if (init_q && step_q != INIT_LAST) begin
            step_d  = step_q + 3'd1;
            state_d = S_INIT;
          end else begin
            init_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_PON;
    endcase

    // In 4-bit mode the active nibble always rides on D7..D4.
    if (BUS4) begin
      bus_d = {low_d ? byte_d[3:0] : byte_d[7:4], 4'h0};
    end else begin
      bus_d = byte_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_PON;
      wsel_q     <= W_EXEC;
      byte_q     <= 8'h00;
      rs_q       <= 1'b0;
      low_q      <= 1'b0;
      single_q   <= 1'b0;
      init_q     <= 1'b0;
      step_q     <= 3'd0;
      ready_q    <= 1'b0;
      en_q       <= 1'b0;
      regsel_q   <= 1'b0;
      lcd_data_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      wsel_q   <= wsel_d;
      byte_q   <= byte_d;
      rs_q     <= rs_d;
      low_q    <= low_d;
      single_q <= single_d;
      init_q   <= init_d;
      step_q   <= step_d;
      ready_q  <= (state_d == S_IDLE);
      en_q     <= (state_d == S_PULSE);
      if (state_d == S_SETUP && state_q != S_SETUP) begin
        lcd_data_q <= bus_d;
        regsel_q   <= rs_d;
      end
    end
  end

  assign ready      = ready_q;
  assign lcd_en     = en_q;
  assign lcd_regsel = regsel_q;
  assign lcd_data   = lcd_data_q;
  assign lcd_r1w0   = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// tb/tb_lcd_hd44780_ctrl.sv - directed bench for lcd_hd44780_ctrl in 8-bit and 4-bit bus modes
module tb_lcd_hd44780_ctrl;

  localparam int EXP_PON  = 500;
  localparam int EXP_AS   = 3;
  localparam int EXP_PW   = 23;
  localparam int EXP_H    = 1;
  localparam int EXP_EXEC = 2000;
  localparam int EXP_LONG = 8200;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       reset_n = 1'b0, write = 1'b0, data1cmd0 = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, lcd_en, lcd_regsel, lcd_r1w0;
  logic [7:0] lcd_data;

  logic       d4_reset_n = 1'b0, d4_write = 1'b0, d4_rs = 1'b0;
  logic [7:0] d4_data = 8'h00;
  logic       d4_ready, d4_en, d4_regsel, d4_r1w0;
  logic [7:0] d4_lcd_data;

  lcd_hd44780_ctrl #(
    .CLK_HZ(50_000_000), .BUS_4BIT(0), .T_LONG_US(164), .T_PON_US(10),
    .T_INIT1_US(20), .T_INIT2_US(4)
  ) u_dut8 (
    .clk(clk), .reset_n(reset_n), .data(data), .write(write), .data1cmd0(data1cmd0),
    .ready(ready), .lcd_data(lcd_data), .lcd_en(lcd_en), .lcd_regsel(lcd_regsel),
    .lcd_r1w0(lcd_r1w0)
  );

  lcd_hd44780_ctrl #(
    .CLK_HZ(50_000_000), .BUS_4BIT(1), .T_LONG_US(164), .T_PON_US(10),
    .T_INIT1_US(20), .T_INIT2_US(4)
  ) u_dut4 (
    .clk(clk), .reset_n(d4_reset_n), .data(d4_data), .write(d4_write), .data1cmd0(d4_rs),
    .ready(d4_ready), .lcd_data(d4_lcd_data), .lcd_en(d4_en), .lcd_regsel(d4_regsel),
    .lcd_r1w0(d4_r1w0)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] cap_d [8];
  logic       cap_rs [8];
  int cap_n, cap_cycles, cap_first_rise, cap_first_fall, cap_last_fall;
  bit cap_timeout;

  logic [7:0] cmd_tab [4] = '{8'h01, 8'h02, 8'h04, 8'h00};
  int         cmd_exp [4] = '{EXP_H + EXP_LONG, EXP_H + EXP_LONG, EXP_H + EXP_EXEC, EXP_H + EXP_EXEC};

  task automatic wait_ready(input bit sel, output bit to);
    int n;
    n = 0;
    to = 0;
    @(negedge clk);
    while (!(sel ? d4_ready : ready) && !to) begin
      @(negedge clk);
      n++;
      if (n > 20000) to = 1;
    end
  endtask

  // Records every EN rising edge until ready is seen or the cycle bound expires.
  task automatic capture(input bit sel, input int bound);
    logic en_s, prev, rdy;
    bit done;
    cap_n = 0; cap_cycles = 0; cap_timeout = 0;
    cap_first_rise = -1; cap_first_fall = -1; cap_last_fall = -1;
    prev = 1'b0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      en_s = sel ? d4_en : lcd_en;
      rdy  = sel ? d4_ready : ready;
      if (rdy) begin
        done = 1;
      end else begin
        if (en_s && !prev) begin
          if (cap_n < 8) begin
            cap_d[cap_n]  = sel ? d4_lcd_data : lcd_data;
            cap_rs[cap_n] = sel ? d4_regsel : lcd_regsel;
          end
          if (cap_first_rise < 0) cap_first_rise = cap_cycles;
          cap_n++;
        end
        if (!en_s && prev) begin
          if (cap_first_fall < 0) cap_first_fall = cap_cycles;
          cap_last_fall = cap_cycles;
        end
        prev = en_s;
        cap_cycles++;
        if (cap_cycles >= bound) begin
          cap_timeout = 1;
          done = 1;
        end
      end
    end
  endtask

  task automatic do_write8(input logic [7:0] b, input logic rs,
                           output logic rdy_after, output logic [7:0] d_setup,
                           output logic rs_setup, output int n_setup, output int n_pulse,
                           output logic [7:0] d_hold, output int n_wait, output bit to);
    wait_ready(0, to);
    data = b; data1cmd0 = rs; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    rdy_after = ready; d_setup = lcd_data; rs_setup = lcd_regsel;
    n_setup = 0;
    while (!lcd_en && n_setup < 100) begin n_setup++; @(negedge clk); end
    n_pulse = 0;
    while (lcd_en && n_pulse < 100) begin n_pulse++; @(negedge clk); end
    d_hold = lcd_data;
    n_wait = 0;
    while (!ready && n_wait < 20000) begin n_wait++; @(negedge clk); end
    if (n_wait >= 20000) to = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({ready, lcd_en, lcd_regsel, lcd_r1w0, lcd_data} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_outputs8: got rdy=%b en=%b rs=%b rw=%b d=%h expected all 0",
               ready, lcd_en, lcd_regsel, lcd_r1w0, lcd_data);
    end
    tests_run++;
    if ({d4_ready, d4_en, d4_regsel, d4_r1w0, d4_lcd_data} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_outputs4: got rdy=%b en=%b d=%h expected all 0", d4_ready, d4_en, d4_lcd_data);
    end
  endtask

  task automatic check_init8(input string tag);
    logic [7:0] exp_d [4];
    exp_d = '{8'h30, 8'h30, 8'h30, 8'h38};
    tests_run++;
    if (cap_timeout !== 1'b0) begin tests_failed++; $display("FAIL %s_timeout: ready never rose", tag); end
    tests_run++;
    if (cap_first_rise < EXP_PON) begin
      tests_failed++; $display("FAIL %s_pon_wait: first EN at %0d expected >= %0d", tag, cap_first_rise, EXP_PON);
    end
    tests_run++;
    if (cap_n !== 4) begin tests_failed++; $display("FAIL %s_pulses: got %0d expected 4", tag, cap_n); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (cap_d[i] !== exp_d[i] || cap_rs[i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_byte%0d: got d=%h rs=%b expected d=%h rs=0", tag, i, cap_d[i], cap_rs[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_init_8bit();
    reset_n = 1'b1;
    capture(0, 20000);
    check_init8("init8");
  endtask

  task automatic test_write_8bit();
    logic rdy_after, rs_setup;
    logic [7:0] d_setup, d_hold;
    int n_setup, n_pulse, n_wait;
    bit to;
    do_write8(8'hAB, 1'b1, rdy_after, d_setup, rs_setup, n_setup, n_pulse, d_hold, n_wait, to);
    tests_run++;
    if (rdy_after !== 1'b0) begin tests_failed++; $display("FAIL wr_ready_drop: got %b expected 0", rdy_after); end
    tests_run++;
    if (d_setup !== 8'hAB || rs_setup !== 1'b1) begin
      tests_failed++; $display("FAIL wr_setup_bus: got d=%h rs=%b expected d=ab rs=1", d_setup, rs_setup);
    end
    tests_run++;
    if (n_setup !== EXP_AS) begin tests_failed++; $display("FAIL wr_setup_cycles: got %0d expected %0d", n_setup, EXP_AS); end
    tests_run++;
    if (n_pulse !== EXP_PW) begin tests_failed++; $display("FAIL wr_pulse_cycles: got %0d expected %0d", n_pulse, EXP_PW); end
    tests_run++;
    if (d_hold !== 8'hAB) begin tests_failed++; $display("FAIL wr_hold_data: got %h expected ab", d_hold); end
    tests_run++;
    if (to || n_wait !== EXP_H + EXP_EXEC) begin
      tests_failed++; $display("FAIL wr_exec_cycles: got %0d expected %0d", n_wait, EXP_H + EXP_EXEC);
    end
  endtask

  task automatic test_long_cmds();
    logic rdy_after, rs_setup;
    logic [7:0] d_setup, d_hold;
    int n_setup, n_pulse, n_wait;
    bit to;
    for (int i = 0; i < 4; i++) begin
      do_write8(cmd_tab[i], 1'b0, rdy_after, d_setup, rs_setup, n_setup, n_pulse, d_hold, n_wait, to);
      tests_run++;
      if (to || n_wait !== cmd_exp[i] || rs_setup !== 1'b0) begin
        tests_failed++;
        $display("FAIL cmd_%h_wait: got %0d rs=%b expected %0d rs=0", cmd_tab[i], n_wait, rs_setup, cmd_exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int np, cyc;
    logic prev, rdy_at_poke;
    bit to;
    wait_ready(0, to);
    data = 8'h55; data1cmd0 = 1'b1; write = 1'b1;
    np = 0; cyc = 0; prev = 1'b0; rdy_at_poke = 1'bx;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) write = 1'b0;
      if (cyc == 40) begin data = 8'h99; data1cmd0 = 1'b0; write = 1'b1; rdy_at_poke = ready; end
      if (cyc == 41) write = 1'b0;
      if (lcd_en && !prev) np++;
      prev = lcd_en;
    end while (!ready && cyc < 20000);
    tests_run++;
    if (to || cyc >= 20000) begin tests_failed++; $display("FAIL b2b_timeout: cycles %0d", cyc); end
    tests_run++;
    if (rdy_at_poke !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy_ready: got %b expected 0", rdy_at_poke); end
    tests_run++;
    if (np !== 1) begin tests_failed++; $display("FAIL b2b_pulse_count: got %0d expected 1", np); end
    tests_run++;
    if (lcd_data !== 8'h55 || lcd_regsel !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_data: got d=%h rs=%b expected d=55 rs=1", lcd_data, lcd_regsel);
    end
    repeat (5) @(negedge clk);
    tests_run++;
    if (ready !== 1'b1 || lcd_en !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_no_pending: got rdy=%b en=%b expected rdy=1 en=0", ready, lcd_en);
    end
  endtask

  task automatic test_4bit();
    logic [7:0] exp_init [6];
    bit to;
    exp_init = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h20, 8'h80};
    d4_reset_n = 1'b1;
    capture(1, 20000);
    tests_run++;
    if (cap_timeout || cap_n !== 6) begin
      tests_failed++; $display("FAIL init4_pulses: got %0d timeout=%b expected 6", cap_n, cap_timeout);
    end
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (cap_d[i] !== exp_init[i] || cap_rs[i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL init4_nibble%0d: got d=%h rs=%b expected d=%h rs=0", i, cap_d[i], cap_rs[i], exp_init[i]);
      end
    end
    wait_ready(1, to);
    d4_data = 8'hAB; d4_rs = 1'b1; d4_write = 1'b1;
    @(negedge clk);
    d4_write = 1'b0;
    capture(1, 20000);
    tests_run++;
    if (cap_timeout || cap_n !== 2) begin
      tests_failed++; $display("FAIL wr4_pulses: got %0d timeout=%b expected 2", cap_n, cap_timeout);
    end
    tests_run++;
    if (cap_d[0] !== 8'hA0 || cap_d[1] !== 8'hB0 || cap_rs[0] !== 1'b1 || cap_rs[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL wr4_nibbles: got %h/%h rs=%b%b expected a0/b0 rs=11", cap_d[0], cap_d[1], cap_rs[0], cap_rs[1]);
    end
    tests_run++;
    if (cap_first_rise - cap_first_fall > 50 || cap_first_fall < 0) begin
      tests_failed++;
      $display("FAIL wr4_gap: gap %0d expected < 50", cap_first_rise - cap_first_fall);
    end
    tests_run++;
    if (cap_cycles - cap_last_fall !== EXP_H + EXP_EXEC) begin
      tests_failed++;
      $display("FAIL wr4_exec: got %0d expected %0d", cap_cycles - cap_last_fall, EXP_H + EXP_EXEC);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int n;
    bit to;
    logic en_before;
    wait_ready(0, to);
    data = 8'h77; data1cmd0 = 1'b1; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    n = 0;
    while (!lcd_en && n < 100) begin n++; @(negedge clk); end
    repeat (5) @(negedge clk);
    en_before = lcd_en;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (en_before !== 1'b1) begin tests_failed++; $display("FAIL rstmid_in_pulse: got en=%b expected 1", en_before); end
    tests_run++;
    if ({ready, lcd_en, lcd_regsel, lcd_r1w0, lcd_data} !== 12'h000) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: got rdy=%b en=%b rs=%b d=%h expected all 0", ready, lcd_en, lcd_regsel, lcd_data);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    capture(0, 20000);
    check_init8("reinit8");
  endtask

  initial begin
    test_reset();
    test_init_8bit();
    test_write_8bit();
    test_long_cmds();
    test_back_to_back();
    test_4bit();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
Parametrised successor to the team's basic character-LCD write driver for HD44780-compatible panels.
- Accepts byte writes (command or data) over a ready/write handshake and generates bus timing from real-time parameters.
- Supports 8-bit and 4-bit bus modes, runs the power-on initialisation sequence itself, and applies the long execution delay for clear/home commands.
- Sits between the host-side packet/command logic and the LCD pins.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
BUS_4BIT, 0, 0 = 8-bit bus; 1 = 4-bit bus on lcd_data[7:4]
T_AS_NS, 60, RS/data setup time before EN rises
T_PW_NS, 460, EN high pulse width
T_H_NS, 20, data/RS hold time after EN falls
T_EXEC_US, 40, execution wait for normal commands and data
T_LONG_US, 1640, execution wait for clear (0x01) and home (0x02/0x03)
T_PON_US, 40000, power-on wait before the init sequence starts

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
data  in  8  byte to write
write  in  1  write strobe; accepted only when ready=1
data1cmd0  in  1  1 = data register (RS=1), 0 = command (RS=0)
ready  out  1  high when idle and able to accept a write
lcd_data  out  8  LCD D7..D0; in 4-bit mode [3:0] is driven 0
lcd_en  out  1  LCD enable strobe
lcd_regsel  out  1  LCD RS
lcd_r1w0  out  1  LCD R/W; constant 0 (write-only block)

Behaviour:
- Reset: asynchronous, active-low. While reset_n=0: ready=0, lcd_en=0, lcd_regsel=0, lcd_r1w0=0, lcd_data=0. Reset mid-operation aborts immediately: lcd_en drops asynchronously and the power-on wait restarts.
- Cycle conversion: cycles = ceil(t * CLK_HZ / 1e9) for ns values (likewise for us values), minimum 1. At 50 MHz: AS=3, PW=23, H=1, EXEC=2000, LONG=82000.
- All outputs are registered.
- States:
  - PON: wait T_PON_US.
  - INIT: step through the init ROM.
  - IDLE: ready=1.
  - SETUP: RS/data driven, lcd_en=0, for AS cycles.
  - PULSE: lcd_en=1 for PW cycles.
  - HOLD: lcd_en=0, data/RS held, for H cycles.
  - NEXT: in 4-bit mode, loop to SETUP for the low nibble.
  - EXEC: wait.
- Init ROM, RS=0:
  - 8-bit mode: 0x30 wait 4100 us; 0x30 wait 100 us; 0x30 wait EXEC; 0x38 wait EXEC.
  - 4-bit mode: nibble 3 wait 4100 us; nibble 3 wait 100 us; nibble 3 wait EXEC; nibble 2 wait EXEC; then byte 0x28 as two nibbles, wait EXEC.
  - Single-nibble init steps emit one pulse only.
- After init completes, the block enters IDLE and ready rises.
- Handshake:
  - Write accepted on the rising clock edge where ready=1 and write=1. data and data1cmd0 are captured then; ready=0 from the next cycle.
  - write while ready=0 is ignored. write held high across consecutive cycles yields exactly one transfer.
- 4-bit mode: high nibble first, then low nibble, each with full SETUP/PULSE/HOLD; there is no EXEC between nibbles.
- EXEC begins after the final HOLD cycle:
  - LONG wait if data1cmd0=0 and data[7:2]=0 with data != 0.
  - Otherwise EXEC wait.
  - Command 0x00 uses EXEC.
- Returns to IDLE when EXEC expires; ready rises in that cycle.

Decomposition:
- Package lcd_pkg holds:
  - state enum;
  - ns/us-to-cycles constant function;
  - init ROM constants (0x30, 0x38, 0x28, nibble 2);
  - fixed init waits of 4100 us and 100 us;
  - long-command decode mask.
- One sub-module, lcd_delay_timer: loadable down-counter, width sized from the largest cycle count, with load/value inputs and a done pulse output. It is shared by all waits.

Test Plan:
- 8-bit mode, T_PON_US=10, release reset -> ready=0 for at least 500 cycles; four EN pulses with lcd_data 0x30,0x30,0x30,0x38 and regsel=0; then ready=1.
- 8-bit mode, write 0xAB with data1cmd0=1:
  - ready=0 on the next cycle;
  - lcd_data=0xAB and regsel=1 for 3 cycles before lcd_en rises;
  - lcd_en high for exactly 23 cycles, data held 1 cycle after it falls;
  - ready returns after 2000 further cycles.
- 4-bit mode, same write -> two EN pulses with lcd_data[7:4]=0xA then 0xB and lcd_data[3:0]=0; single EXEC wait after the second pulse.
- Command 0x01 -> EXEC 82000 cycles; command 0x02 -> 82000; command 0x04 -> 2000.
- write held high for 3 cycles while idle -> exactly one EN pulse sequence; write pulsed while ready=0 -> no extra pulse and data unchanged.
- Assert reset_n low during PULSE -> lcd_en=0 immediately, all outputs at reset values; after release the full power-on wait and init ROM repeat.
